// File: rtl/ultrasonic_sensor_uart_command_rx_pkg.sv
// Shared UART line settings and host command codes for the HC-SR04 serial control path.
package ultrasonic_sensor_uart_command_rx_pkg;

  localparam int UART_BAUD_RATE  = 9600;
  localparam int UART_OVERSAMPLE = 16;

  localparam logic [7:0] CMD_START_p = 8'h53;  // 'S'
  localparam logic [7:0] CMD_STOP_p  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_INCH_p  = 8'h49;  // 'I'
  localparam logic [7:0] CMD_CM_p    = 8'h43;  // 'C'

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/ultrasonic_sensor_uart_tick_gen.sv
// Oversample tick generator: free-running 0..DIV-1 divider, held at 0 while clr is high.
module ultrasonic_sensor_uart_tick_gen #(
  parameter int DIV = 326
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/ultrasonic_sensor_uart_command_rx.sv
// UART 8N1 receiver (16x oversampled) with a decoder that turns host command
// characters into the measurement-enable and unit-select registers.
module ultrasonic_sensor_uart_command_rx
  import ultrasonic_sensor_uart_command_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = UART_BAUD_RATE,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Rx_i,
  output logic [7:0] Data_o,
  output logic       Data_valid_o,
  output logic       Frame_error_o,
  output logic       Busy_o,
  output logic       Switch_o,
  output logic       Cm_or_inches_o
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic       rx_m, rx_s;
  logic [2:0] state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       tick;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx_i;
      rx_s <= rx_m;
    end
  end

  ultrasonic_sensor_uart_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (Clk_i),
    .rst_n (Reset_i),
    .clr   (state == ST_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state          <= ST_IDLE;
      tick_cnt       <= 4'd0;
      bit_cnt        <= 3'd0;
      shift          <= 8'h00;
      Data_o         <= 8'h00;
      Data_valid_o   <= 1'b0;
      Frame_error_o  <= 1'b0;
      Switch_o       <= 1'b0;
      Cm_or_inches_o <= 1'b0;
    end else begin
      Data_valid_o  <= 1'b0;
      Frame_error_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          tick_cnt <= 4'd0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            // Mid start bit: a line that is high again was only a glitch.
            if (tick_cnt == 4'd7) begin
              tick_cnt <= 4'd0;
              bit_cnt  <= 3'd0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shift   <= {rx_s, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            if (tick_cnt == 4'd15) begin
              if (rx_s) begin
                state        <= ST_IDLE;
                Data_o       <= shift;
                Data_valid_o <= 1'b1;
                case (shift)
                  CMD_START_p: Switch_o       <= 1'b1;
                  CMD_STOP_p:  Switch_o       <= 1'b0;
                  CMD_INCH_p:  Cm_or_inches_o <= 1'b1;
                  CMD_CM_p:    Cm_or_inches_o <= 1'b0;
                  default:     ;
                endcase
              end else begin
                state         <= ST_WAIT_IDLE;
                Frame_error_o <= 1'b1;
              end
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_sensor_uart_command_rx.sv
// Directed bench for the UART command receiver, run at a scaled clock/baud (DIV=10, 160 clocks/bit).
module tb_ultrasonic_sensor_uart_command_rx;

  localparam int BIT_CLKS = 160;
  localparam int IDLE_CLKS = 400;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic       sw;
  logic       cm;

  int checks;
  int failures;

  ultrasonic_sensor_uart_command_rx #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD_RATE  (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .Clk_i         (clk),
    .Reset_i       (rst_n),
    .Rx_i          (rx),
    .Data_o        (data),
    .Data_valid_o  (data_valid),
    .Frame_error_o (frame_error),
    .Busy_o        (busy),
    .Switch_o      (sw),
    .Cm_or_inches_o(cm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: cumulative counts plus control values seen in each valid cycle.
  int   n_valid = 0;
  int   n_ferr  = 0;
  int   n_both  = 0;
  logic sw_hist[$];
  logic cm_hist[$];

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid <= n_valid + 1;
      sw_hist.push_back(sw);
      cm_hist.push_back(cm);
    end
    if (frame_error) n_ferr <= n_ferr + 1;
    if (data_valid && frame_error) n_both <= n_both + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b, input int bclk);
    rx = 1'b0;
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bclk);
    end
    rx = stop_b;
    wait_clks(bclk);
  endtask

  typedef struct {
    logic [7:0] byte_in;
    logic       stop_bit;
    int         hold_low;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
    logic       exp_sw;
    logic       exp_cm;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int v0, f0, b0;
    checks   = 0;
    failures = 0;
    rx       = 1'b1;
    rst_n    = 1'b0;

    vecs[0] = '{8'h41, 1'b1, 0,    1, 0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'h53, 1'b1, 0,    1, 0, 8'h53, 1'b1, 1'b0};
    vecs[2] = '{8'h49, 1'b1, 0,    1, 0, 8'h49, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 0,    1, 0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h43, 1'b1, 0,    1, 0, 8'h43, 1'b1, 1'b0};
    vecs[5] = '{8'h50, 1'b0, 3200, 0, 1, 8'h43, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 0,    1, 0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h50, 1'b1, 0,    1, 0, 8'h50, 1'b0, 1'b0};
    vecs[8] = '{8'h73, 1'b1, 0,    1, 0, 8'h73, 1'b0, 1'b0};
    vecs[9] = '{8'h49, 1'b1, 0,    1, 0, 8'h49, 1'b0, 1'b1};

    // Reset state, then a quiet idle line.
    wait_clks(5);
    chk("rst_data",  {24'd0, data}, 32'h00);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_error}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_sw",    {31'd0, sw}, 32'd0);
    chk("rst_cm",    {31'd0, cm}, 32'd0);
    rst_n = 1'b1;
    wait_clks(2000);
    chk("idle_no_valid", n_valid, 0);
    chk("idle_no_ferr",  n_ferr, 0);
    chk("idle_busy",     {31'd0, busy}, 32'd0);

    for (int k = 0; k < 10; k++) begin
      v0 = n_valid;
      f0 = n_ferr;
      send_byte(vecs[k].byte_in, vecs[k].stop_bit, BIT_CLKS);
      if (vecs[k].hold_low > 0) begin
        wait_clks(vecs[k].hold_low);
        chk($sformatf("v%0d_busy_low", k), {31'd0, busy}, 32'd1);
      end
      rx = 1'b1;
      wait_clks(IDLE_CLKS);
      chk($sformatf("v%0d_valid_cnt", k), n_valid - v0, vecs[k].exp_valid);
      chk($sformatf("v%0d_ferr_cnt", k),  n_ferr - f0,  vecs[k].exp_ferr);
      chk($sformatf("v%0d_data", k), {24'd0, data}, {24'd0, vecs[k].exp_data});
      chk($sformatf("v%0d_sw", k),   {31'd0, sw},   {31'd0, vecs[k].exp_sw});
      chk($sformatf("v%0d_cm", k),   {31'd0, cm},   {31'd0, vecs[k].exp_cm});
      chk($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd0);
      if (vecs[k].exp_valid == 1 && n_valid > v0) begin
        chk($sformatf("v%0d_sw_at_valid", k), {31'd0, sw_hist[v0]}, {31'd0, vecs[k].exp_sw});
        chk($sformatf("v%0d_cm_at_valid", k), {31'd0, cm_hist[v0]}, {31'd0, vecs[k].exp_cm});
      end
    end

    // Back-to-back 'I' then 'C' with no idle gap between frames.
    wait_clks(IDLE_CLKS);
    v0 = n_valid;
    send_byte(8'h49, 1'b1, BIT_CLKS);
    send_byte(8'h43, 1'b1, BIT_CLKS);
    wait_clks(IDLE_CLKS);
    chk("b2b_valid_cnt", n_valid - v0, 2);
    if (n_valid - v0 == 2) begin
      chk("b2b_cm_first",  {31'd0, cm_hist[v0]},     32'd1);
      chk("b2b_cm_second", {31'd0, cm_hist[v0 + 1]}, 32'd0);
    end
    chk("b2b_data", {24'd0, data}, 32'h43);

    // Short low glitch: rejected at mid start bit.
    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    wait_clks(10);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    wait_clks(20);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    chk("glitch_valid",   n_valid - v0, 0);
    chk("glitch_ferr",    n_ferr - f0, 0);

    // Reset asserted during bit 4 of 'S' and held until the frame is over.
    wait_clks(IDLE_CLKS);
    v0 = n_valid;
    f0 = n_ferr;
    fork
      send_byte(8'h53, 1'b1, BIT_CLKS);
      begin
        wait_clks(BIT_CLKS * 5 + BIT_CLKS / 2);
        rst_n = 1'b0;
        wait_clks(3);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data", {24'd0, data}, 32'h00);
        chk("midrst_cm",   {31'd0, cm}, 32'd0);
      end
    join
    wait_clks(200);
    rst_n = 1'b1;
    wait_clks(IDLE_CLKS);
    chk("midrst_no_valid", n_valid - v0, 0);
    chk("midrst_no_ferr",  n_ferr - f0, 0);
    chk("midrst_sw",       {31'd0, sw}, 32'd0);

    // 'S' at -2% and +2% baud.
    v0 = n_valid;
    f0 = n_ferr;
    b0 = n_both;
    send_byte(8'h53, 1'b1, 163);
    wait_clks(IDLE_CLKS);
    chk("slow_valid_cnt", n_valid - v0, 1);
    chk("slow_sw", {31'd0, sw}, 32'd1);
    send_byte(8'h50, 1'b1, 157);
    wait_clks(IDLE_CLKS);
    chk("fast_valid_cnt", n_valid - v0, 2);
    chk("fast_data", {24'd0, data}, 32'h50);
    chk("fast_sw",   {31'd0, sw}, 32'd0);
    send_byte(8'h53, 1'b1, 157);
    wait_clks(IDLE_CLKS);
    chk("tol_valid_cnt", n_valid - v0, 3);
    chk("tol_ferr_cnt",  n_ferr - f0, 0);
    chk("tol_data",      {24'd0, data}, 32'h53);
    chk("tol_sw",        {31'd0, sw}, 32'd1);
    chk("tol_both",      n_both - b0, 0);

    chk("never_both", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
